// File: rtl/reflet_ram_wide.sv
// -----------------------------------------------------------------------------
// reflet_ram_wide
//
// General-purpose synchronous single-port RAM for Reflet cores wider than
// 8 bits. The word width is a multiple of 8, and each 8-bit lane has its own
// write enable. After reset, an optional clear engine walks the whole array
// and writes zero to every word. The `ready` flag stays low until that clear
// finishes, and no access is accepted while it is low.
//
// Ports:
//   clk       : system clock; all state changes on its rising edge
//   reset     : asynchronous reset, active low
//   enable    : access strobe; nothing is read or written while low
//   addr      : word address
//   data_in   : write data
//   write_en  : write request, qualified by enable
//   byte_en   : per-lane write mask, bit k covers data bits [8k+7:8k]
//   data_out  : registered read data (one cycle latency)
//   ready     : high when the RAM accepts accesses
//   state_dbg : current FSM state (0 = CLEAR, 1 = IDLE), for observation only
//
// Handshake: an access is taken on a rising clk edge when
//   ready && enable && (addr < size). A taken access always loads data_out
//   on that edge, and also writes the array when write_en is set. With
//   ready && enable && addr >= size, data_out loads zero and nothing is
//   written. With enable low, or with ready low, data_out holds its value.
// -----------------------------------------------------------------------------
module reflet_ram_wide #(
    parameter int wordSize  = 16,
    parameter int addrSize  = 8,
    parameter int size      = 256,
    parameter int resetable = 1,
    parameter int rdwMode   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [addrSize-1:0]     addr,
    input  logic [wordSize-1:0]     data_in,
    input  logic                    write_en,
    input  logic [wordSize/8-1:0]   byte_en,
    output logic [wordSize-1:0]     data_out,
    output logic                    ready,
    output logic                    state_dbg
);

    localparam int LANES = wordSize / 8;
    // Index width of the storage array. The upper address bits are only
    // non-zero for out-of-range addresses, and those never reach the array.
    localparam int IDXW  = (size > 1) ? $clog2(size) : 1;

    // The counter and the size constants are one bit wider than the address.
    // This lets size = 2^addrSize be compared and terminated without wrapping.
    localparam logic [addrSize:0] SIZE_W = (addrSize + 1)'(size);
    localparam logic [addrSize:0] LAST_W = (addrSize + 1)'(size - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [addrSize:0]     clr_cnt;
    logic [addrSize:0]     clr_cnt_next;
    logic                  ready_next;

    logic [wordSize-1:0]   mem [size];

    logic                  in_range;
    logic                  usable;
    logic                  do_write;
    logic [LANES-1:0]      lane_we;
    logic                  clear_we;
    logic [IDXW-1:0]       acc_idx;
    logic [IDXW-1:0]       clr_idx;
    logic [wordSize-1:0]   rd_word;
    logic [wordSize-1:0]   merged;
    logic [wordSize-1:0]   read_val;

    assign state_dbg = logic'(state);

    // ---------------------------------------------------------------------
    // Access qualification
    // ---------------------------------------------------------------------
    assign in_range = ({1'b0, addr} < SIZE_W);
    assign usable   = ready && enable && in_range;
    assign do_write = usable && write_en;
    assign lane_we  = do_write ? byte_en : '0;

    // Out-of-range addresses are steered to word 0. This keeps every array
    // read inside bounds. The result is discarded in that case anyway.
    assign acc_idx  = in_range ? addr[IDXW-1:0] : '0;
    assign clr_idx  = clr_cnt[IDXW-1:0];

    // The clear engine only writes while the reset input is released.
    // This keeps the array untouched during reset.
    assign clear_we = (resetable != 0) && (state == S_CLEAR) && reset;

    assign rd_word  = mem[acc_idx];

    // This is the word as it looks after this edge's lane writes.
    // It is used when read-during-write returns the new data.
    always_comb begin
        merged = rd_word;
        for (int k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
                merged[8*k +: 8] = data_in[8*k +: 8];
            end
        end
    end

    assign read_val = (rdwMode != 0) ? merged : rd_word;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= (resetable != 0) ? S_CLEAR : S_IDLE;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            ready   <= ready_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ready rises on the same edge that writes the last word of the clear.
    // With no clear engine, it rises on the first edge after release.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        ready_next   = ready;
        case (state)
            S_CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_W) begin
                    state_next = S_IDLE;
                    ready_next = 1'b1;
                end
            end
            S_IDLE: begin
                ready_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
                ready_next = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Storage array. It is not reset, so contents survive a reset pulse
    // until the clear engine overwrites them. Clear writes and user writes
    // never overlap, because user writes need ready.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_we[k]) begin
                    mem[acc_idx][8*k +: 8] <= data_in[8*k +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read data register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (ready && enable) begin
            data_out <= in_range ? read_val : '0;
        end
    end

endmodule

// File: tb/tb_reflet_ram_wide.sv
module tb_reflet_ram_wide;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: size 256, old data on read-during-write
  logic        rst_a, en_a, we_a, rdy_a, st_a;
  logic [7:0]  addr_a;
  logic [15:0] din_a, dout_a;
  logic [1:0]  be_a;

  // DUT B: size 200, new data on read-during-write
  logic        rst_b, en_b, we_b, rdy_b, st_b;
  logic [7:0]  addr_b;
  logic [15:0] din_b, dout_b;
  logic [1:0]  be_b;

  reflet_ram_wide #(.wordSize(16), .addrSize(8), .size(256), .resetable(1), .rdwMode(0)) u_dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .addr(addr_a), .data_in(din_a),
    .write_en(we_a), .byte_en(be_a), .data_out(dout_a), .ready(rdy_a), .state_dbg(st_a)
  );

  reflet_ram_wide #(.wordSize(16), .addrSize(8), .size(200), .resetable(1), .rdwMode(1)) u_dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .addr(addr_b), .data_in(din_b),
    .write_en(we_b), .byte_en(be_b), .data_out(dout_b), .ready(rdy_b), .state_dbg(st_b)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  bit issue_a = 1'b0;
  bit issue_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: the edge after an issued access, compare data_out with the queue head
  always @(posedge clk) begin : mon_a
    logic [15:0] e;
    if (issue_a) begin
      #1;
      if (exp_q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_a: got 0x%0h with no expected value queued", dout_a);
      end else begin
        e = exp_q_a.pop_front();
        check("read_a", dout_a, e);
      end
    end
  end

  always @(posedge clk) begin : mon_b
    logic [15:0] e;
    if (issue_b) begin
      #1;
      if (exp_q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_b: got 0x%0h with no expected value queued", dout_b);
      end else begin
        e = exp_q_b.pop_front();
        check("read_b", dout_b, e);
      end
    end
  end

  // One access for one cycle, followed by an idle cycle
  task automatic acc(input bit sel, input logic [7:0] a, input logic we, input logic [1:0] be,
                     input logic [15:0] d, input logic [15:0] e);
    @(negedge clk);
    if (!sel) begin
      en_a = 1'b1; addr_a = a; we_a = we; be_a = be; din_a = d;
      exp_q_a.push_back(e); issue_a = 1'b1;
    end else begin
      en_b = 1'b1; addr_b = a; we_b = we; be_b = be; din_b = d;
      exp_q_b.push_back(e); issue_b = 1'b1;
    end
    @(negedge clk);
    en_a = 1'b0; we_a = 1'b0; issue_a = 1'b0;
    en_b = 1'b0; we_b = 1'b0; issue_b = 1'b0;
  endtask

  // Count rising edges until ready reads 1 (bounded)
  task automatic wait_ready(input bit sel, output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      n++;
      if ((sel ? rdy_b : rdy_a) == 1'b1) break;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst_a = 1'b0; en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = '0; din_a = '0;
    rst_b = 1'b0; en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = '0; din_b = '0;
    repeat (3) @(negedge clk);
    check("reset_ready_a", rdy_a, 0);
    check("reset_dout_a", dout_a, 0);
    check("reset_ready_b", rdy_b, 0);
    check("reset_dout_b", dout_b, 0);

    // Release A with a write to addr 9 held on the bus during the whole clear
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 8'd9; din_a = 16'hFFFF;
    rst_a = 1'b1;
    wait_ready(1'b0, n);
    check("clear_edges_a", n, 256);
    check("dout_during_clear_a", dout_a, 0);
    @(negedge clk);
    en_a = 1'b0; we_a = 1'b0;

    acc(0, 8'd0,   0, 2'b00, 16'h0000, 16'h0000);
    acc(0, 8'd128, 0, 2'b00, 16'h0000, 16'h0000);
    acc(0, 8'd255, 0, 2'b00, 16'h0000, 16'h0000);
    acc(0, 8'd9,   0, 2'b00, 16'h0000, 16'h0000);

    // Byte lanes, old data on read-during-write
    acc(0, 8'd5, 1, 2'b11, 16'hABCD, 16'h0000);
    acc(0, 8'd5, 1, 2'b01, 16'h1234, 16'hABCD);
    acc(0, 8'd5, 0, 2'b00, 16'h0000, 16'hAB34);
    acc(0, 8'd5, 1, 2'b00, 16'hFFFF, 16'hAB34);
    acc(0, 8'd5, 0, 2'b00, 16'h0000, 16'hAB34);
    acc(0, 8'd7, 1, 2'b11, 16'h1111, 16'h0000);
    acc(0, 8'd7, 1, 2'b11, 16'h2222, 16'h1111);
    acc(0, 8'd7, 0, 2'b00, 16'h0000, 16'h2222);
    acc(0, 8'd5, 1, 2'b10, 16'h5600, 16'hAB34);
    acc(0, 8'd5, 0, 2'b00, 16'h0000, 16'h5634);

    // Enable low: data_out holds its value and the write is ignored
    @(negedge clk);
    addr_a = 8'd0; we_a = 1'b1; be_a = 2'b11; din_a = 16'hFFFF; en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("enable_low_hold_a", dout_a, 16'h5634);
    end
    @(negedge clk);
    we_a = 1'b0;
    acc(0, 8'd0, 0, 2'b00, 16'h0000, 16'h0000);

    // Reset during idle with data_out non-zero
    acc(0, 8'd5, 0, 2'b00, 16'h0000, 16'h5634);
    #2 rst_a = 1'b0;
    #1;
    check("async_reset_dout_a", dout_a, 0);
    check("async_reset_ready_a", rdy_a, 0);
    @(negedge clk);
    rst_a = 1'b1;

    // Reset at clear counter 100
    repeat (100) @(posedge clk);
    #1;
    check("mid_clear_not_ready_a", rdy_a, 0);
    #2 rst_a = 1'b0;
    #1;
    check("mid_clear_reset_ready_a", rdy_a, 0);
    check("mid_clear_reset_dout_a", dout_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    wait_ready(1'b0, n);
    check("reclear_edges_a", n, 256);
    acc(0, 8'd0, 0, 2'b00, 16'h0000, 16'h0000);
    acc(0, 8'd5, 0, 2'b00, 16'h0000, 16'h0000);
    acc(0, 8'd7, 0, 2'b00, 16'h0000, 16'h0000);

    // DUT B: size 200, new data on read-during-write
    @(negedge clk);
    rst_b = 1'b1;
    wait_ready(1'b1, n);
    check("clear_edges_b", n, 200);
    acc(1, 8'd210, 1, 2'b11, 16'hFFFF, 16'h0000);
    acc(1, 8'd10,  0, 2'b00, 16'h0000, 16'h0000);
    acc(1, 8'd10,  1, 2'b11, 16'h2222, 16'h2222);
    acc(1, 8'd10,  1, 2'b10, 16'h3300, 16'h3322);
    acc(1, 8'd10,  0, 2'b00, 16'h0000, 16'h3322);
    acc(1, 8'd200, 0, 2'b00, 16'h0000, 16'h0000);
    acc(1, 8'd199, 1, 2'b01, 16'h00AA, 16'h00AA);
    acc(1, 8'd255, 1, 2'b11, 16'hFFFF, 16'h0000);
    acc(1, 8'd199, 0, 2'b00, 16'h0000, 16'h00AA);
    acc(1, 8'd10,  1, 2'b00, 16'hFFFF, 16'h3322);
    acc(1, 8'd55,  0, 2'b00, 16'h0000, 16'h0000);

    @(negedge clk);
    check("queue_a_drained", exp_q_a.size(), 0);
    check("queue_b_drained", exp_q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reflet_ram_wide.md
Name: reflet_ram_wide

Overview:
Parametrised synchronous single-port RAM with a configurable word width (multiple of 8) and per-byte write enables. It includes a sequential clear engine that zeroes the whole array after reset, and a `ready` flag that gates all accesses. It is the general-purpose memory for Reflet cores wider than 8 bits, and it replaces per-byte ram8 instances.

Parameters:
- wordSize, 16, data width in bits; must be a multiple of 8 (lanes = wordSize/8).
- addrSize, 8, address width in bits.
- size, 256, number of words implemented; must be ≤ 2^addrSize.
- resetable, 1, 1 = clear engine zeroes the array after reset; 0 = no clear, contents undefined at power-up.
- rdwMode, 0, read-during-write on the same address: 0 = old data returned, 1 = new (merged) data returned.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- enable, input, 1, access strobe; no read or write occurs when low.
- addr, input, addrSize, word address.
- data_in, input, wordSize, write data.
- write_en, input, 1, write request; qualified by enable.
- byte_en, input, wordSize/8, per-lane write mask; bit k covers data bits [8k+7:8k].
- data_out, output, wordSize, registered read data.
- ready, output, 1, high when the RAM accepts accesses.

Behaviour:
- **Reset (reset=0, async):**
  - state forced to CLEAR if resetable=1, otherwise IDLE.
  - clear counter = 0, ready = 0, data_out = 0.
  - Array contents are not touched asynchronously.
- **FSM states: CLEAR and IDLE.**
  - CLEAR: on each clk edge after reset release, write all-zero to word[counter], then counter += 1.
  - When counter = size-1 is written, the next state is IDLE and ready = 1 from that same edge.
  - The clear sequence therefore takes exactly `size` clock edges, and ready first reads 1 after edge number `size`.
  - resetable=0: ready rises on the first clk edge after reset release.
- **While ready=0:** enable, write_en and byte_en are ignored; data_out stays 0.
- **Usable access:** usable = ready && enable && (addr < size), sampled at the clk edge.
- **Write:** on a usable access with write_en=1, for each lane k with byte_en[k]=1, word[addr] lane k ← data_in lane k. Other lanes are unchanged. byte_en = 0 means no write.
- **Read:** on every usable access, including writes, data_out ← word[addr] at the next edge (latency 1 cycle).
  - rdwMode=0: data_out shows the pre-write contents.
  - rdwMode=1: data_out shows the post-write merged word.
- **Out of range:** an access with enable=1, ready=1 and addr ≥ size is not usable.
  - No write occurs.
  - data_out ← 0 at that edge.
- **enable=0:** data_out holds its previous value; no memory change.
- **Reset mid-clear or mid-access:** everything returns to the reset state immediately. After release, the clear restarts from address 0 (resetable=1).
  - An interrupted write is either completed before the reset assertion edge or not performed; there is no partial lane corruption.
- **Widths:**
  - The counter is addrSize+1 bits wide so size = 2^addrSize terminates correctly.
  - No arithmetic is performed on data.

Test Plan:
1. **Clear sequence.** size=256, resetable=1. Release reset and count edges until ready=1 → exactly 256. Then read addresses 0, 128 and 255 → each returns 0x0000 one cycle after addr is presented.
2. **Byte-lane write.**
   - Write 0xABCD to addr 5 with byte_en=11, then write 0x1234 with byte_en=01. Read addr 5 → 0xAB34.
   - Write with byte_en=00 → addr 5 still 0xAB34.
3. **Read-during-write.** addr 7 holds 0x1111; write 0x2222 to addr 7 with byte_en=11 → next-cycle data_out is 0x1111 with rdwMode=0, or 0x2222 with rdwMode=1. A following read returns 0x2222 in both modes.
4. **Out of range.** size=200, addrSize=8. Write 0xFFFF to addr 210 → data_out = 0 next cycle. Then read addr 210−size=10 → still 0 (no aliasing).
5. **Enable and ready gating.**
   - Read addr 5 (0xAB34), then drop enable for 3 cycles → data_out stays 0xAB34.
   - Issue writes while ready=0 during clear → after clear, the targeted address reads 0.
6. **Reset mid-clear.** Assert reset at clear counter = 100 → ready = 0 and data_out = 0 immediately (asynchronously). After release, ready rises after exactly 256 more edges and addr 0 reads 0.
